// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operand-select encodings, instruction field layout
// and memory-map defaults used by the decode stage.
package cpu_pkg;

    typedef enum logic [1:0] {
        ALU_SRC_RR  = 2'b00,
        ALU_SRC_RI  = 2'b01,
        ALU_SRC_SH  = 2'b10,
        ALU_SRC_SPR = 2'b11
    } alu_src_e;

    localparam int INSTR_W     = 32;
    localparam int RS_LSB      = 21;
    localparam int RT_LSB      = 16;
    localparam int RD_LSB      = 11;
    localparam int SHAMT_LSB   = 6;
    localparam int SNUM_LSB    = 0;
    localparam int IMM_LSB     = 0;
    localparam int REG_FIELD_W = 5;
    localparam int SHAMT_W     = 5;
    localparam int SNUM_W      = 6;
    localparam int IMM_W       = 16;

    localparam logic [31:0] SPRITE_BASE_DEFAULT = 32'h0000_0C00;

    typedef struct packed {
        logic [REG_FIELD_W-1:0] rs;
        logic [REG_FIELD_W-1:0] rt;
        logic [REG_FIELD_W-1:0] rd;
        logic [SHAMT_W-1:0]     shamt;
        logic [SNUM_W-1:0]      snum;
        logic [IMM_W-1:0]       imm;
    } instr_fields_t;

    // rd, shamt and snum overlap imm; each view is extracted independently.
    function automatic instr_fields_t decode_fields(input logic [INSTR_W-1:0] instr);
        instr_fields_t f;
        f.rs    = instr[RS_LSB    +: REG_FIELD_W];
        f.rt    = instr[RT_LSB    +: REG_FIELD_W];
        f.rd    = instr[RD_LSB    +: REG_FIELD_W];
        f.shamt = instr[SHAMT_LSB +: SHAMT_W];
        f.snum  = instr[SNUM_LSB  +: SNUM_W];
        f.imm   = instr[IMM_LSB   +: IMM_W];
        return f;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with combinational reads and write-through
// bypass, so a value being written back is visible to decode in the same cycle.
module regfile_2r1w #(
    parameter int  XLEN     = 32,
    parameter int  NREGS    = 32,
    parameter bit  ZERO_REG = 1'b1,
    localparam int RA       = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA-1:0]   ra1,
    output logic [XLEN-1:0] rd1,
    input  logic [RA-1:0]   ra2,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [RA-1:0]   wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_en;

    assign wr_en = we && !(ZERO_REG && (wa == '0));

    // NOTE: the array is reset explicitly because software relies on every
    // register reading zero after reset; this forces flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = regs[ra1];
        if (wr_en && (wa == ra1)) rd1 = wd;
        if (ZERO_REG && (ra1 == '0)) rd1 = '0;
    end

    always_comb begin
        rd2 = regs[ra2];
        if (wr_en && (wa == ra2)) rd2 = wd;
        if (ZERO_REG && (ra2 == '0)) rd2 = '0;
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: register read, ALU operand selection, load-use
// hazard stall and the ID/EX pipeline register with valid/ready handshake.
module id_stage_pipe
    import cpu_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter int          NREGS       = 32,
    parameter bit          ZERO_REG    = 1'b1,
    parameter logic [31:0] SPRITE_BASE = SPRITE_BASE_DEFAULT,
    parameter int          STACK_STEP  = 1,
    parameter int          CNT_W       = 16,
    localparam int         RA          = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      if_instr,
    input  logic [XLEN-1:0]  if_pc,
    input  logic [1:0]       alu_src,
    input  logic             stack_op,
    input  logic             rs_used,
    input  logic             rt_used,
    input  logic             wb_we,
    input  logic [RA-1:0]    wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [RA-1:0]    ex_rd,
    input  logic             ex_ready,
    input  logic             flush,
    output logic             id_valid,
    output logic [XLEN-1:0]  id_op1,
    output logic [XLEN-1:0]  id_op2,
    output logic [XLEN-1:0]  id_rt_data,
    output logic [RA-1:0]    id_rd,
    output logic [XLEN-1:0]  id_pc,
    output logic [CNT_W-1:0] stall_cnt
);

    instr_fields_t   fields;
    logic [RA-1:0]   rs_addr, rt_addr, rd_addr;
    logic [XLEN-1:0] rs_data, rt_data;
    logic [XLEN-1:0] op1_nxt, op2_nxt;
    logic            ex_rd_live, hazard, accept;

    assign fields  = decode_fields(if_instr);
    assign rs_addr = fields.rs[RA-1:0];
    assign rt_addr = fields.rt[RA-1:0];
    assign rd_addr = fields.rd[RA-1:0];

    regfile_2r1w #(
        .XLEN    (XLEN),
        .NREGS   (NREGS),
        .ZERO_REG(ZERO_REG)
    ) u_regfile (
        .clk(clk),
        .rst(rst),
        .ra1(rs_addr),
        .rd1(rs_data),
        .ra2(rt_addr),
        .rd2(rt_data),
        .we (wb_we),
        .wa (wb_addr),
        .wd (wb_data)
    );

    // A load targeting the hard-wired zero register can never produce a dependency.
    assign ex_rd_live = (ex_rd != '0) || !ZERO_REG;
    assign hazard     = ex_valid && ex_is_load && ex_rd_live &&
                        ((rs_used && (ex_rd == rs_addr)) || (rt_used && (ex_rd == rt_addr)));
    assign if_ready   = (!id_valid || ex_ready) && !hazard && !flush;
    assign accept     = if_valid && if_ready;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        op1_nxt = rs_data;
        op2_nxt = rt_data;
        unique case (alu_src_e'(alu_src))
            ALU_SRC_RR:  ;
            ALU_SRC_RI:  op2_nxt = XLEN'($signed(fields.imm));
            ALU_SRC_SH:  op2_nxt = stack_op ? XLEN'(STACK_STEP) : XLEN'(fields.shamt);
            ALU_SRC_SPR: begin
                op1_nxt = XLEN'(SPRITE_BASE);
                op2_nxt = XLEN'(fields.snum);
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid   <= 1'b0;
            id_op1     <= '0;
            id_op2     <= '0;
            id_rt_data <= '0;
            id_rd      <= '0;
            id_pc      <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (accept) begin
            id_valid   <= 1'b1;
            id_op1     <= op1_nxt;
            id_op2     <= op2_nxt;
            id_rt_data <= rt_data;
            id_rd      <= rd_addr;
            id_pc      <= if_pc;
        end else if (ex_ready) begin
            id_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (if_valid && hazard && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios plus a randomized run
// compared against a behavioural model of the decode stage.
module tb_id_stage_pipe;

    typedef struct packed {
        logic        valid;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] rt_data;
        logic [4:0]  rd;
        logic [31:0] pc;
    } id_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, if_ready;
    logic [31:0] if_instr, if_pc;
    logic [1:0]  alu_src;
    logic        stack_op, rs_used, rt_used;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_valid, ex_is_load;
    logic [4:0]  ex_rd;
    logic        ex_ready, flush;
    logic        id_valid;
    logic [31:0] id_op1, id_op2, id_rt_data, id_pc;
    logic [4:0]  id_rd;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_rf [32];
    id_t         exp_id;
    int          exp_stall;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .alu_src   (alu_src),
        .stack_op  (stack_op),
        .rs_used   (rs_used),
        .rt_used   (rt_used),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .ex_valid  (ex_valid),
        .ex_is_load(ex_is_load),
        .ex_rd     (ex_rd),
        .ex_ready  (ex_ready),
        .flush     (flush),
        .id_valid  (id_valid),
        .id_op1    (id_op1),
        .id_op2    (id_op2),
        .id_rt_data(id_rt_data),
        .id_rd     (id_rd),
        .id_pc     (id_pc),
        .stall_cnt (stall_cnt)
    );

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_we && wb_addr == a) return wb_data;
        return model_rf[a];
    endfunction

    function automatic id_t ref_decode();
        id_t         r;
        logic [15:0] imm;
        imm       = if_instr[15:0];
        r.valid   = 1'b1;
        r.rt_data = ref_read(if_instr[20:16]);
        r.rd      = if_instr[15:11];
        r.pc      = if_pc;
        r.op1     = ref_read(if_instr[25:21]);
        r.op2     = ref_read(if_instr[20:16]);
        case (alu_src)
            2'b01: r.op2 = {{16{imm[15]}}, imm};
            2'b10: r.op2 = stack_op ? 32'd1 : {27'd0, if_instr[10:6]};
            2'b11: begin
                r.op1 = 32'h0000_0C00;
                r.op2 = {26'd0, if_instr[5:0]};
            end
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic ref_hazard();
        return ex_valid && ex_is_load && (ex_rd != 5'd0) &&
               ((rs_used && ex_rd == if_instr[25:21]) || (rt_used && ex_rd == if_instr[20:16]));
    endfunction

    function automatic logic ref_ready();
        return (!exp_id.valid || ex_ready) && !ref_hazard() && !flush;
    endfunction

    function automatic id_t snap();
        return '{valid: id_valid, op1: id_op1, op2: id_op2, rt_data: id_rt_data, rd: id_rd, pc: id_pc};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        exp_id    = '0;
        exp_stall = 0;
    endtask

    // Advance the model by one clock using the current inputs, then step the DUT.
    task automatic cycle();
        logic hz, rdy;
        id_t  nxt;
        hz  = ref_hazard();
        rdy = ref_ready();
        nxt = ref_decode();
        if (if_valid && hz && !flush && exp_stall < 16'hFFFF) exp_stall++;
        if (flush)                 exp_id.valid = 1'b0;
        else if (if_valid && rdy)  exp_id = nxt;
        else if (ex_ready)         exp_id.valid = 1'b0;
        if (wb_we && wb_addr != 5'd0) model_rf[wb_addr] = wb_data;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        if_valid = 0; if_instr = 0; if_pc = 0; alu_src = 0; stack_op = 0;
        rs_used = 0; rt_used = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
        ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_ready = 1; flush = 0;
    endtask

    task automatic present(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm,
                           input logic [1:0] mode, input logic stk, input logic [31:0] pc);
        if_valid = 1; if_instr = {6'h23, rs, rt, imm}; alu_src = mode;
        stack_op = stk; if_pc = pc; rs_used = 1; rt_used = 1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_we = 1; wb_addr = a; wb_data = d;
        cycle();
        wb_we = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 0;
        idle();
        model_reset();
        #12;
        checks++;
        if ({id_valid, id_op1, id_op2, id_rt_data, id_rd, id_pc, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs act=%h exp=0", {id_valid, id_op1, id_op2, id_rt_data, id_rd, id_pc, stall_cnt});
        end
        @(posedge clk); #1;
        rst = 1;
        #1;
        checks++;
        if (if_ready !== 1'b1) begin
            errors++; $display("FAIL reset_if_ready act=%b exp=1", if_ready);
        end
        cycle();
        checks++;
        if (id_valid !== 1'b0) begin
            errors++; $display("FAIL reset_idle_valid act=%b exp=0", id_valid);
        end
    endtask

    task automatic test_rr_bypass_hold();
        id_t held;
        wb_write(5'd3, 32'd5);
        wb_write(5'd4, 32'd7);
        present(5'd3, 5'd4, {5'd9, 11'd0}, 2'b00, 1'b0, 32'h100);
        #1;
        checks++;
        if (if_ready !== 1'b1) begin
            errors++; $display("FAIL rr_ready act=%b exp=1", if_ready);
        end
        cycle();
        checks++;
        if ({id_valid, id_op1, id_op2, id_rt_data, id_rd, id_pc} !== {1'b1, 32'd5, 32'd7, 32'd7, 5'd9, 32'h100}) begin
            errors++;
            $display("FAIL rr_load act=%h exp=%h", snap(), {1'b1, 32'd5, 32'd7, 32'd7, 5'd9, 32'h100});
        end
        held = snap();
        ex_ready = 0;
        present(5'd4, 5'd3, 16'h0000, 2'b00, 1'b0, 32'h104);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (if_ready !== 1'b0) begin
                errors++; $display("FAIL hold_ready cyc=%0d act=%b exp=0", i, if_ready);
            end
            cycle();
            checks++;
            if (snap() !== held) begin
                errors++; $display("FAIL hold_stable cyc=%0d act=%h exp=%h", i, snap(), held);
            end
        end
        ex_ready = 1;
        cycle();
        checks++;
        if (snap() !== exp_id || id_op1 !== 32'd7 || id_op2 !== 32'd5) begin
            errors++; $display("FAIL hold_release act=%h exp=%h", snap(), exp_id);
        end
        if_valid = 0;
        cycle();
        checks++;
        if (id_valid !== 1'b0) begin
            errors++; $display("FAIL drain act=%b exp=0", id_valid);
        end
    endtask

    task automatic test_ri_bypass();
        present(5'd5, 5'd4, 16'hFFFE, 2'b01, 1'b0, 32'h200);
        wb_we = 1; wb_addr = 5'd5; wb_data = 32'hABCD_1234;
        cycle();
        wb_we = 0;
        present(5'd5, 5'd3, 16'h1234, 2'b01, 1'b0, 32'h204);
        checks++;
        if (id_op1 !== 32'hABCD_1234 || id_op2 !== 32'hFFFF_FFFE || id_rt_data !== 32'd7 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL ri_bypass act=%h/%h/%h exp=abcd1234/fffffffe/00000007", id_op1, id_op2, id_rt_data);
        end
        cycle();
        if_valid = 0;
        checks++;
        if (snap() !== exp_id || id_op2 !== 32'h0000_1234) begin
            errors++; $display("FAIL ri_positive act=%h exp=%h", snap(), exp_id);
        end
    endtask

    task automatic test_sh_spr();
        present(5'd2, 5'd0, 16'h0240, 2'b10, 1'b0, 32'h300);
        cycle();
        checks++;
        if (id_op2 !== 32'd9 || snap() !== exp_id) begin
            errors++; $display("FAIL sh_shamt act=%h exp=00000009", id_op2);
        end
        stack_op = 1;
        cycle();
        checks++;
        if (id_op2 !== 32'd1 || snap() !== exp_id) begin
            errors++; $display("FAIL sh_stack act=%h exp=00000001", id_op2);
        end
        present(5'd2, 5'd0, 16'h002A, 2'b11, 1'b0, 32'h308);
        cycle();
        if_valid = 0;
        checks++;
        if (id_op1 !== 32'h0000_0C00 || id_op2 !== 32'h0000_002A || snap() !== exp_id) begin
            errors++; $display("FAIL spr act=%h/%h exp=00000c00/0000002a", id_op1, id_op2);
        end
        cycle();
    endtask

    task automatic test_load_use();
        present(5'd1, 5'd2, 16'h0000, 2'b00, 1'b0, 32'h400);
        cycle();
        present(5'd3, 5'd1, 16'h0800, 2'b00, 1'b0, 32'h404);
        rt_used = 0;
        ex_valid = 1; ex_is_load = 1; ex_rd = 5'd3; ex_ready = 1;
        #1;
        checks++;
        if (if_ready !== 1'b0) begin
            errors++; $display("FAIL load_use_ready act=%b exp=0", if_ready);
        end
        cycle();
        checks++;
        if (id_valid !== 1'b0) begin
            errors++; $display("FAIL load_use_bubble act=%b exp=0", id_valid);
        end
        cycle();
        checks++;
        if (stall_cnt !== 16'd2 || int'(stall_cnt) != exp_stall) begin
            errors++; $display("FAIL load_use_count act=%0d exp=2", stall_cnt);
        end
        ex_valid = 0;
        #1;
        checks++;
        if (if_ready !== 1'b1) begin
            errors++; $display("FAIL load_use_clear act=%b exp=1", if_ready);
        end
        cycle();
        if_valid = 0; ex_is_load = 0;
        checks++;
        if (snap() !== exp_id || id_pc !== 32'h404 || id_op1 !== 32'd5) begin
            errors++; $display("FAIL load_use_accept act=%h exp=%h", snap(), exp_id);
        end
    endtask

    task automatic test_flush();
        present(5'd6, 5'd0, 16'h0000, 2'b00, 1'b0, 32'h500);
        cycle();
        ex_ready = 0; flush = 1;
        present(5'd7, 5'd0, 16'h0000, 2'b00, 1'b0, 32'h504);
        wb_we = 1; wb_addr = 5'd7; wb_data = 32'h0000_7777;
        #1;
        checks++;
        if (if_ready !== 1'b0 || id_valid !== 1'b1) begin
            errors++; $display("FAIL flush_ready act=%b/%b exp=0/1", if_ready, id_valid);
        end
        cycle();
        flush = 0; wb_we = 0; if_valid = 0;
        checks++;
        if (id_valid !== 1'b0) begin
            errors++; $display("FAIL flush_kill act=%b exp=0", id_valid);
        end
        cycle();
        checks++;
        if (id_valid !== 1'b0) begin
            errors++; $display("FAIL flush_drop act=%b exp=0", id_valid);
        end
        ex_ready = 1;
        present(5'd7, 5'd7, 16'h0000, 2'b00, 1'b0, 32'h508);
        cycle();
        if_valid = 0;
        checks++;
        if (id_op1 !== 32'h0000_7777 || id_op2 !== 32'h0000_7777 || snap() !== exp_id) begin
            errors++; $display("FAIL flush_wb act=%h/%h exp=00007777/00007777", id_op1, id_op2);
        end
    endtask

    task automatic test_async_reset();
        present(5'd3, 5'd4, 16'h0000, 2'b00, 1'b0, 32'h600);
        cycle();
        ex_ready = 0; if_valid = 0;
        cycle();
        #2;
        rst = 0;
        model_reset();
        #1;
        checks++;
        if ({id_valid, id_op1, id_op2, id_rt_data, id_rd, id_pc, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset act=%h exp=0", {id_valid, id_op1, id_op2, id_rt_data, id_rd, id_pc, stall_cnt});
        end
        idle();
        @(posedge clk); #1;
        rst = 1;
        present(5'd3, 5'd4, 16'h0000, 2'b00, 1'b0, 32'h700);
        cycle();
        if_valid = 0;
        checks++;
        if (id_op1 !== 32'd0 || id_op2 !== 32'd0 || id_valid !== 1'b1) begin
            errors++; $display("FAIL reset_regfile act=%h/%h exp=0/0", id_op1, id_op2);
        end
    endtask

    task automatic test_zero_reg();
        wb_write(5'd0, 32'hDEAD_BEEF);
        present(5'd0, 5'd0, 16'h0000, 2'b00, 1'b0, 32'h800);
        wb_we = 1; wb_addr = 5'd0; wb_data = 32'h1111_1111;
        ex_valid = 1; ex_is_load = 1; ex_rd = 5'd0;
        #1;
        checks++;
        if (if_ready !== 1'b1) begin
            errors++; $display("FAIL zero_hazard act=%b exp=1", if_ready);
        end
        cycle();
        idle();
        checks++;
        if (id_op1 !== 32'd0 || id_op2 !== 32'd0 || id_rt_data !== 32'd0) begin
            errors++; $display("FAIL zero_reg act=%h/%h/%h exp=0/0/0", id_op1, id_op2, id_rt_data);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            if_valid   = ($urandom % 4) != 0;
            if_instr   = $urandom();
            if_instr[25:21] = 5'($urandom_range(0, 7));
            if_instr[20:16] = 5'($urandom_range(0, 7));
            if_pc      = $urandom();
            alu_src    = 2'($urandom);
            stack_op   = 1'($urandom);
            rs_used    = 1'($urandom);
            rt_used    = 1'($urandom);
            wb_we      = 1'($urandom);
            wb_addr    = 5'($urandom_range(0, 7));
            wb_data    = $urandom();
            ex_valid   = 1'($urandom);
            ex_is_load = 1'($urandom);
            ex_rd      = 5'($urandom_range(0, 7));
            ex_ready   = ($urandom % 4) != 0;
            flush      = ($urandom % 16) == 0;
            #1;
            checks++;
            if (if_ready !== ref_ready()) begin
                errors++; $display("FAIL rnd_ready n=%0d act=%b exp=%b", n, if_ready, ref_ready());
            end
            cycle();
            checks++;
            if (exp_id.valid ? (snap() !== exp_id) : (id_valid !== 1'b0)) begin
                errors++; $display("FAIL rnd_id n=%0d act=%h exp=%h", n, snap(), exp_id);
            end
            checks++;
            if (int'(stall_cnt) != exp_stall) begin
                errors++; $display("FAIL rnd_stall n=%0d act=%0d exp=%0d", n, stall_cnt, exp_stall);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_rr_bypass_hold();
        test_ri_bypass();
        test_sh_spr();
        test_load_use();
        test_flush();
        test_async_reset();
        test_zero_reg();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
